axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave
Interface
REQ-001 ADDR_W, default 12, word-index width; storage is 2^ADDR_W 32-bit words.
REQ-002 aclk  in  1  sole clock; all state updates on rising edge.
REQ-003 aresetn  in  1  asynchronous, active-low reset.
REQ-004 arid  in  4  read request id.
REQ-005 araddr  in  32  read start byte address.
REQ-006 arlen  in  8  read beats minus one (INCR only, 4-byte beats).
REQ-007 arvalid  in  1  read address valid.
REQ-008 arready  out  1  read address accepted.
REQ-009 rid  out  4  captured arid.
REQ-010 rdata  out  32  read data beat.
REQ-011 rresp  out  2  read response, constant 2'b00.
REQ-012 rlast  out  1  final read beat.
REQ-013 rvalid  out  1  read data valid.
REQ-014 rready  in  1  master accepts read beat.
REQ-015 awid  in  4  write request id.
REQ-016 awaddr  in  32  write start byte address.
REQ-017 awlen  in  4  write beats minus one (INCR only, 4-byte beats).
REQ-018 awvalid  in  1  write address valid.
REQ-019 awready  out  1  write address accepted.
REQ-020 wid  in  4  write data id, ignored.
REQ-021 wdata  in  32  write data beat.
REQ-022 wstrb  in  4  byte enables; wstrb[i] gates wdata[8i+7:8i].
REQ-023 wlast  in  1  final write beat marker from master.
REQ-024 wvalid  in  1  write data valid.
REQ-025 wready  out  1  slave accepts write beat.
REQ-026 bid  out  4  captured awid.
REQ-027 bresp  out  2  write response, constant 2'b00.
REQ-028 bvalid  out  1  write response valid.
REQ-029 bready  in  1  master accepts write response.
Function
REQ-030 FSM states IDLE, RD, WR, BRESP; one transaction outstanding at a time.
REQ-031 IDLE: arready=awready=1 only when the respective valid is sampled while in IDLE; with both valid the same cycle, read wins and aw is not accepted.
REQ-032 AR handshake in IDLE: capture arid, word index araddr[ADDR_W+1:2], beat counter=arlen; go RD.
REQ-033 RD: rdata=mem[index] registered, rvalid asserted the cycle after AR acceptance, held with stable rdata/rid until rready.
REQ-034 Each rvalid&rready: index+1, counter-1, next beat valid next cycle; rlast=1 when counter==0; beat with rlast returns to IDLE.
REQ-035 AW handshake in IDLE: capture awid, index, counter=awlen; go WR.
REQ-036 WR: wready=1; each wvalid&wready writes enabled bytes to mem[index], index+1, counter-1.
REQ-037 Burst ends on beat with counter==0 regardless of wlast; go BRESP.
REQ-038 BRESP: bvalid=1 with bid until bready; then IDLE, awready low that cycle.
REQ-039 Index arithmetic is modulo 2^ADDR_W; address bits above ADDR_W+1 and bits [1:0] are ignored.
REQ-040 Read of a word written in an earlier completed burst returns the new value; no same-cycle read/write overlap occurs.
Reset
REQ-041 aresetn low: state IDLE, arready=awready=wready=rvalid=rlast=bvalid=0, rid=bid=0, rdata=0; memory contents not cleared; abandons any burst immediately.
Verification
REQ-042 Write 0xDEADBEEF to 0x10 (awlen 0, wstrb F), read 0x10 -> bvalid once with bid=awid, rdata=0xDEADBEEF, rlast=1, rid=arid.
REQ-043 Write wstrb 4'b0101 data 0x11223344 over 0xDEADBEEF at 0x10 -> read returns 0xDE22BE44.
REQ-044 4-beat write 1,2,3,4 at 0x20 then arlen 3 read with rready toggling every cycle -> 1,2,3,4, rlast only on beat 4, rdata stable while stalled.
REQ-045 arvalid and awvalid same cycle -> read completes first, aw accepted after return to IDLE, bvalid follows.
REQ-046 Write at index 2^ADDR_W-1 with awlen 1 -> second beat lands at index 0; aresetn pulse mid read burst -> rvalid=0 next edge, memory retained.

Source files
------------

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
//   Single-outstanding AXI3-style slave in front of a 2^ADDR_W x 32-bit SRAM.
//   Serves one INCR burst (4-byte beats) at a time. A read burst returns
//   registered data beats. A write burst stores byte-enabled beats and then
//   returns a single write response.
//
// Ports
//   aclk, aresetn                 clock, asynchronous active-low reset
//   arid/araddr/arlen/arvalid     read address channel (in)
//   arready                       read address accepted (out)
//   rid/rdata/rresp/rlast/rvalid  read data channel (out)
//   rready                        read data accepted by master (in)
//   awid/awaddr/awlen/awvalid     write address channel (in)
//   awready                       write address accepted (out)
//   wid/wdata/wstrb/wlast/wvalid  write data channel (in; wid, wlast unused)
//   wready                        write beat accepted (out)
//   bid/bresp/bvalid              write response channel (out)
//   bready                        write response accepted by master (in)
// -----------------------------------------------------------------------------
module axi_sram_slave #(
    parameter int ADDR_W = 12
) (
    input  logic        aclk,
    input  logic        aresetn,
    // read address
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    // read data
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // write address
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic        awvalid,
    output logic        awready,
    // write data
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD    = 2'd1,
        S_WR    = 2'd2,
        S_BRESP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [31:0]         r_mem [DEPTH];

    logic [ADDR_W-1:0]   r_idx;
    logic [7:0]          r_cnt;
    logic [31:0]         r_rdata;
    logic [3:0]          r_rid;
    logic [3:0]          r_bid;
    logic                r_rlast;
    logic                r_rvalid;
    logic                r_wready;
    logic                r_bvalid;

    logic [ADDR_W-1:0]   w_ar_idx;
    logic [ADDR_W-1:0]   w_aw_idx;
    logic [ADDR_W-1:0]   w_idx_inc;
    logic                w_ar_hs;
    logic                w_aw_hs;
    logic                w_r_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_unused_bits;

    // Word index: byte-address bits [1:0] and everything above ADDR_W+1 drop out.
    assign w_ar_idx  = araddr[ADDR_W+1:2];
    assign w_aw_idx  = awaddr[ADDR_W+1:2];
    // Wraps naturally modulo 2^ADDR_W.
    assign w_idx_inc = r_idx + ADDR_W'(1);

    // Address handshakes are only offered in IDLE, and only while the matching
    // valid is high; a simultaneous read request takes priority over the write.
    // aresetn gating keeps the ready lines low while reset is asserted.
    assign w_ar_hs = aresetn && (r_state == S_IDLE) && arvalid;
    assign w_aw_hs = aresetn && (r_state == S_IDLE) && awvalid && !arvalid;
    assign w_r_hs  = (r_state == S_RD) && r_rvalid && rready;
    // The burst length counter, not wlast, decides where the write burst ends.
    assign w_w_hs  = (r_state == S_WR) && r_wready && wvalid;
    assign w_b_hs  = (r_state == S_BRESP) && r_bvalid && bready;

    assign arready = w_ar_hs;
    assign awready = w_aw_hs;
    assign rid     = r_rid;
    assign rdata   = r_rdata;
    assign rresp   = 2'b00;
    assign rlast   = r_rlast;
    assign rvalid  = r_rvalid;
    assign wready  = r_wready;
    assign bid     = r_bid;
    assign bresp   = 2'b00;
    assign bvalid  = r_bvalid;

    // Inputs the slave deliberately ignores.
    assign w_unused_bits = ^{wid, wlast, araddr[31:ADDR_W+2], araddr[1:0],
                             awaddr[31:ADDR_W+2], awaddr[1:0]};

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ar_hs) begin
                    w_next = S_RD;
                end else if (w_aw_hs) begin
                    w_next = S_WR;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RD: begin
                if (w_r_hs && r_rlast) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_RD;
                end
            end
            S_WR: begin
                if (w_w_hs && (r_cnt == 8'd0)) begin
                    w_next = S_BRESP;
                end else begin
                    w_next = S_WR;
                end
            end
            S_BRESP: begin
                if (w_b_hs) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_BRESP;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Channel valid/ready flags, registered from the next-state decode so each
    // flag is high exactly while the FSM sits in the matching state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rvalid <= 1'b0;
            r_wready <= 1'b0;
            r_bvalid <= 1'b0;
        end else begin
            r_rvalid <= (w_next == S_RD);
            r_wready <= (w_next == S_WR);
            r_bvalid <= (w_next == S_BRESP);
        end
    end

    // Burst bookkeeping: index, remaining-beat counter, ids and read data.
    // Read data for the following beat is fetched on the accepting edge so
    // rdata only ever changes on a handshake and stays stable across stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_idx   <= '0;
            r_cnt   <= 8'd0;
            r_rdata <= 32'd0;
            r_rid   <= 4'd0;
            r_bid   <= 4'd0;
            r_rlast <= 1'b0;
        end else if (w_ar_hs) begin
            r_idx   <= w_ar_idx;
            r_cnt   <= arlen;
            r_rdata <= r_mem[w_ar_idx];
            r_rid   <= arid;
            r_rlast <= (arlen == 8'd0);
        end else if (w_aw_hs) begin
            r_idx   <= w_aw_idx;
            r_cnt   <= {4'd0, awlen};
            r_bid   <= awid;
        end else if (w_r_hs) begin
            if (r_rlast) begin
                r_rlast <= 1'b0;
            end else begin
                r_idx   <= w_idx_inc;
                r_cnt   <= r_cnt - 8'd1;
                r_rdata <= r_mem[w_idx_inc];
                r_rlast <= (r_cnt == 8'd1);
            end
        end else if (w_w_hs) begin
            r_idx   <= w_idx_inc;
            r_cnt   <= r_cnt - 8'd1;
        end else begin
            r_idx   <= r_idx;
            r_cnt   <= r_cnt;
        end
    end

    // Byte-enabled SRAM write port; contents survive reset on purpose.
    always_ff @(posedge aclk) begin
        if (w_w_hs) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    r_mem[r_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_slave
//   Directed stimulus for axi_sram_slave. Stimulus tasks push the expected
//   read beats / write responses into queues; an independent monitor pops
//   and compares on every R or B handshake and also checks that a stalled
//   read beat holds its payload.
// -----------------------------------------------------------------------------
module tb_axi_sram_slave;

    localparam int ADDR_W = 12;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    always #5 aclk = ~aclk;

    axi_sram_slave #(.ADDR_W(ADDR_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  id;
        logic        last;
    } rbeat_t;

    rbeat_t     rq[$];
    logic [3:0] bq[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_r(input logic [31:0] d, input logic [3:0] id, input logic last);
        rbeat_t e;
        e.data = d;
        e.id   = id;
        e.last = last;
        rq.push_back(e);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        rbeat_t     e;
        logic [3:0] eb;
        logic       stall_prev;
        logic [31:0] held_data;
        logic [3:0]  held_id;
        logic        held_last;
        stall_prev = 1'b0;
        held_data  = 32'd0;
        held_id    = 4'd0;
        held_last  = 1'b0;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (stall_prev) begin
                    check("r_stall_valid", {31'd0, rvalid}, 32'd1);
                    check("r_stall_data", rdata, held_data);
                    check("r_stall_id", {28'd0, rid}, {28'd0, held_id});
                    check("r_stall_last", {31'd0, rlast}, {31'd0, held_last});
                end
                if (rvalid && rready) begin
                    if (rq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL r_unexpected: got beat %h, expected none", rdata);
                    end else begin
                        e = rq.pop_front();
                        check("rdata", rdata, e.data);
                        check("rid", {28'd0, rid}, {28'd0, e.id});
                        check("rlast", {31'd0, rlast}, {31'd0, e.last});
                        check("rresp", {30'd0, rresp}, 32'd0);
                    end
                end
                stall_prev = rvalid && !rready;
                held_data  = rdata;
                held_id    = rid;
                held_last  = rlast;
                if (bvalid && bready) begin
                    if (bq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL b_unexpected: got bid %h, expected none", bid);
                    end else begin
                        eb = bq.pop_front();
                        check("bid", {28'd0, bid}, {28'd0, eb});
                        check("bresp", {30'd0, bresp}, 32'd0);
                    end
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Wait until the monitor has consumed every pending expectation.
    task automatic wait_drained(input string name, input int budget);
        int t;
        t = 0;
        while ((rq.size() != 0 || bq.size() != 0) && t < budget) begin
            @(posedge aclk);
            #1;
            t++;
        end
        n_checks++;
        if (rq.size() != 0 || bq.size() != 0) begin
            n_fail++;
            $display("FAIL %s: timeout with %0d r / %0d b pending, expected 0", name, rq.size(), bq.size());
            rq.delete();
            bq.delete();
        end
    endtask

    // Wait on the falling edge for a DUT ready line; bounded.
    task automatic wait_ready(input string name, input int which);
        int t;
        logic seen;
        t = 0;
        seen = 1'b0;
        while (!seen && t < 50) begin
            @(negedge aclk);
            case (which)
                0:       seen = arready;
                1:       seen = awready;
                default: seen = wready;
            endcase
            t++;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: ready never seen, got 0 expected 1", name);
        end
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [127:0] d, input logic [15:0] s, input logic [3:0] l);
        @(posedge aclk);
        #1;
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        wait_ready("aw_ready", 1);
        @(posedge aclk);
        #1;
        awvalid = 1'b0;
        bq.push_back(id);
        for (int b = 0; b <= int'(len); b++) begin
            wdata  = d[32*b +: 32];
            wstrb  = s[4*b +: 4];
            wlast  = l[b];
            wvalid = 1'b1;
            wait_ready("w_ready", 2);
            @(posedge aclk);
            #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        wait_drained("b_done", 50);
        bready = 1'b0;
    endtask

    // Expected beats must already be queued by the caller.
    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic toggle);
        int t;
        @(posedge aclk);
        #1;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        wait_ready("ar_ready", 0);
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
        rready  = toggle ? 1'b0 : 1'b1;
        t = 0;
        while (rq.size() != 0 && t < 100) begin
            @(posedge aclk);
            #1;
            if (toggle) rready = ~rready;
            t++;
        end
        rready = 1'b0;
        wait_drained("r_done", 5);
    endtask

    initial begin
        aresetn = 1'b0;
        arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arvalid = 1'b1;
        rready = 1'b0;
        awid = 4'd0; awaddr = 32'd0; awlen = 4'd0; awvalid = 1'b1;
        wid = 4'd0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b0;

        // Reset values, with both address valids high during reset.
        #22;
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rlast", {31'd0, rlast}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rid_bid", {24'd0, rid, bid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        arvalid = 1'b0;
        awvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;

        // Single full-word write, then read back.
        axi_write(4'h3, 32'h0000_0010, 4'd0, {96'd0, 32'hDEAD_BEEF}, 16'h000F, 4'b0001);
        push_r(32'hDEAD_BEEF, 4'h5, 1'b1);
        axi_read(4'h5, 32'h0000_0010, 8'd0, 1'b0);

        // Partial strobe 0101 merges bytes 0 and 2.
        axi_write(4'hA, 32'h0000_0010, 4'd0, {96'd0, 32'h1122_3344}, 16'h0005, 4'b0001);
        push_r(32'hDE22_BE44, 4'h1, 1'b1);
        axi_read(4'h1, 32'h0000_0010, 8'd0, 1'b0);

        // Four-beat write, then four-beat read with rready toggling.
        axi_write(4'h6, 32'h0000_0020, 4'd3,
                  {32'd4, 32'd3, 32'd2, 32'd1}, 16'hFFFF, 4'b1000);
        push_r(32'd1, 4'hC, 1'b0);
        push_r(32'd2, 4'hC, 1'b0);
        push_r(32'd3, 4'hC, 1'b0);
        push_r(32'd4, 4'hC, 1'b1);
        axi_read(4'hC, 32'h0000_0020, 8'd3, 1'b1);

        // Simultaneous AR and AW: read is served first.
        push_r(32'hDE22_BE44, 4'h7, 1'b1);
        @(posedge aclk);
        #1;
        arid = 4'h7; araddr = 32'h0000_0010; arlen = 8'd0; arvalid = 1'b1;
        awid = 4'h9; awaddr = 32'h0000_0040; awlen = 4'd0; awvalid = 1'b1;
        @(negedge aclk);
        check("both_arready", {31'd0, arready}, 32'd1);
        check("both_awready", {31'd0, awready}, 32'd0);
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
        rready  = 1'b1;
        wait_ready("aw_after_read", 1);
        check("read_done_before_aw", 32'(rq.size()), 32'd0);
        bq.push_back(4'h9);
        @(posedge aclk);
        #1;
        awvalid = 1'b0;
        rready  = 1'b0;
        wdata = 32'hCAFE_F00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        wait_ready("w_ready_sim", 2);
        @(posedge aclk);
        #1;
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        wait_drained("b_sim", 50);
        bready = 1'b0;
        push_r(32'hCAFE_F00D, 4'h2, 1'b1);
        axi_read(4'h2, 32'h0000_0040, 8'd0, 1'b0);

        // Wrap at the top index; upper address bits ignored; wlast on the
        // wrong beat must not shorten the burst.
        axi_write(4'hE, 32'hFFFF_3FFC, 4'd1, {64'd0, 32'hA5A5_0002, 32'hA5A5_0001},
                  16'h00FF, 4'b0001);
        push_r(32'hA5A5_0002, 4'h4, 1'b1);
        axi_read(4'h4, 32'h0000_0000, 8'd0, 1'b0);
        push_r(32'hA5A5_0001, 4'h8, 1'b0);
        push_r(32'hA5A5_0002, 4'h8, 1'b1);
        axi_read(4'h8, 32'h0000_3FFF, 8'd1, 1'b0);

        // Reset pulse in the middle of a read burst.
        push_r(32'd1, 4'h2, 1'b0);
        axi_read(4'h2, 32'h0000_0020, 8'd3, 1'b0);
        #2;
        arvalid = 1'b1;
        aresetn = 1'b0;
        #1;
        check("midrst_rvalid", {31'd0, rvalid}, 32'd0);
        check("midrst_rlast", {31'd0, rlast}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_rid", {28'd0, rid}, 32'd0);
        check("midrst_arready", {31'd0, arready}, 32'd0);
        arvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        push_r(32'd1, 4'hB, 1'b0);
        push_r(32'd2, 4'hB, 1'b0);
        push_r(32'd3, 4'hB, 1'b0);
        push_r(32'd4, 4'hB, 1'b1);
        axi_read(4'hB, 32'h0000_0020, 8'd3, 1'b0);

        repeat (3) @(posedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
